// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a fixed 16-entry song table and drives a
// one-hot note select for music_notes. Each note plays for dur tempo ticks,
// followed by GAP_TICKS silent ticks. All outputs come straight from flops.
module melody_sequencer #(
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
   output logic [7:0] note_sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] step_idx
);

   localparam int             CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  TICK_MAX  = CW'(TICK_DIV - 1);
   localparam logic [2:0]     GAP_LOAD  = 3'(GAP_TICKS);
   localparam logic [3:0]     LAST_STEP = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   // Valid/ready does not apply here: start/stop/loop_en are plain levels
   // sampled on every rising edge; outputs change only on clock edges or reset.

   // Song table: entries 0-7 ascend with 1-tick notes, 8-15 descend with 2-tick notes.
   function automatic logic [2:0] note_of(input logic [3:0] idx);
      return idx[3] ? ~idx[2:0] : idx[2:0];
   endfunction

   function automatic logic [2:0] dur_of(input logic [3:0] idx);
      return idx[3] ? 3'd2 : 3'd1;
   endfunction

   state_t        state_q, state_d;
   logic [3:0]    step_q, step_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    rem_q, rem_d;
   logic [7:0]    note_sel_q, note_sel_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          tick;
   logic          step_end;

   assign tick = (cnt_q == TICK_MAX);

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      step_end = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start && !stop) begin
               state_d = S_PLAY;
               step_d  = '0;
               rem_d   = dur_of(4'd0);
            end
         end
         S_PLAY: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               if (rem_q == 3'd1) begin
                  if (GAP_TICKS != 0) begin
                     state_d = S_GAP;
                     rem_d   = GAP_LOAD;
                     cnt_d   = '0;
                  end else begin
                     step_end = 1'b1;
                  end
               end else begin
                  rem_d = rem_q - 3'd1;
               end
            end
         end
         S_GAP: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               if (rem_q == 3'd1) begin
                  step_end = 1'b1;
               end else begin
                  rem_d = rem_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // End of a note+gap pair: advance, wrap on loop, or finish the song.
      if (step_end) begin
         cnt_d = '0;
         if (step_q != LAST_STEP) begin
            state_d = S_PLAY;
            step_d  = step_q + 4'd1;
            rem_d   = dur_of(step_q + 4'd1);
         end else if (loop_en) begin
            state_d = S_PLAY;
            step_d  = '0;
            rem_d   = dur_of(4'd0);
         end else begin
            state_d = S_IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
         end
      end

      // stop overrides everything, including a simultaneous start or song end.
      if (stop) begin
         state_d = S_IDLE;
         step_d  = '0;
         cnt_d   = '0;
         rem_d   = '0;
         done_d  = 1'b0;
      end

      note_sel_d = (state_d == S_PLAY) ? (8'd1 << note_of(step_d)) : 8'd0;
      busy_d     = (state_d != S_IDLE);
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         cnt_q      <= '0;
         rem_q      <= '0;
         note_sel_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         note_sel_q <= note_sel_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign note_sel = note_sel_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step_idx = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: TICK_DIV=4 with a 1-tick gap (dut_g) and
// without a gap (dut_n); both share inputs.
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic [7:0] note_g, note_n;
   logic       busy_g, busy_n;
   logic       done_g, done_n;
   logic [3:0] step_g, step_n;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [3:0] exp_step_q[$];

   typedef struct {
      logic       start;
      logic       stop;
      logic       exp_busy;
      logic [7:0] exp_note;
      logic [3:0] exp_step;
      logic       exp_done;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut_g (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .note_sel(note_g), .busy(busy_g), .done(done_g), .step_idx(step_g)
   );

   melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(0)) dut_n (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .note_sel(note_n), .busy(busy_n), .done(done_n), .step_idx(step_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle note and step for one pass, derived from the song rules.
   task automatic build_song(input int gap_ticks);
      int note;
      int dur;
      exp_q.delete();
      exp_step_q.delete();
      for (int s = 0; s < 16; s++) begin
         note = (s < 8) ? s : 15 - s;
         dur  = (s < 8) ? 1 : 2;
         for (int k = 0; k < dur * 4; k++) begin
            exp_q.push_back(8'(1 << note));
            exp_step_q.push_back(4'(s));
         end
         for (int k = 0; k < gap_ticks * 4; k++) begin
            exp_q.push_back(8'h00);
            exp_step_q.push_back(4'(s));
         end
      end
   endtask

   // Walk one full pass cycle-by-cycle; optionally poke start or drop loop_en.
   task automatic check_pass(input bit nogap, input int poke_at, input int clr_loop_at,
                             input bit expect_end);
      int n;
      build_song(nogap ? 0 : 1);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         chk("pass_note", nogap ? note_n : note_g, exp_q[c]);
         chk("pass_step", nogap ? step_n : step_g, exp_step_q[c]);
         chk("pass_busy", nogap ? busy_n : busy_g, 1);
         chk("pass_done", nogap ? done_n : done_g, 0);
         start = (c == poke_at);
         if (c == clr_loop_at) loop_en = 1'b0;
         tick();
      end
      start = 1'b0;
      if (expect_end) begin
         chk("end_busy", nogap ? busy_n : busy_g, 0);
         chk("end_done", nogap ? done_n : done_g, 1);
         chk("end_note", nogap ? note_n : note_g, 0);
         tick();
         chk("end_done_pulse", nogap ? done_n : done_g, 0);
         chk("end_busy_hold", nogap ? busy_n : busy_g, 0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      //                 start stop busy note   step done
      vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 4'd0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 4'd0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      tick();
      tick();
      chk("rst_note", note_g, 0);
      chk("rst_busy", busy_g, 0);
      chk("rst_done", done_g, 0);
      chk("rst_step", step_g, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy_g, 0);

      // Directed start/stop conflict vectors from IDLE.
      for (int i = 0; i < 7; i++) begin
         start = vecs[i].start;
         stop  = vecs[i].stop;
         tick();
         chk("vec_busy", busy_g, vecs[i].exp_busy);
         chk("vec_note", note_g, vecs[i].exp_note);
         chk("vec_step", step_g, vecs[i].exp_step);
         chk("vec_done", done_g, vecs[i].exp_done);
      end
      start = 1'b0;
      stop  = 1'b0;

      // Single pass, then a pass with start pulsed during step 3.
      pulse_start();
      check_pass(1'b0, -1, -1, 1'b1);
      pulse_start();
      check_pass(1'b0, 26, -1, 1'b1);

      // Loop: wrap to step 0 with busy held, then finish after the second pass.
      loop_en = 1'b1;
      pulse_start();
      check_pass(1'b0, -1, -1, 1'b0);
      check_pass(1'b0, -1, 20, 1'b1);

      // Stop at step 5 mid-note, then restart from step 0.
      pulse_start();
      for (int c = 0; c < 41; c++) tick();
      chk("pre_stop_step", step_g, 5);
      chk("pre_stop_note", note_g, 8'h20);
      pulse_stop();
      chk("stop_note", note_g, 0);
      chk("stop_busy", busy_g, 0);
      chk("stop_step", step_g, 0);
      chk("stop_done", done_g, 0);
      tick();
      tick();
      chk("stop_stays_idle", busy_g, 0);
      chk("stop_no_done", done_g, 0);
      pulse_start();
      chk("restart_note", note_g, 8'h01);
      chk("restart_step", step_g, 0);
      chk("restart_busy", busy_g, 1);

      // Asynchronous reset mid-note: outputs drop before the next clock edge.
      for (int c = 0; c < 9; c++) tick();
      chk("pre_rst_note", note_g, 8'h02);
      #3 rst = 1'b1;
      #1;
      chk("arst_note", note_g, 0);
      chk("arst_busy", busy_g, 0);
      chk("arst_step", step_g, 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_rst_busy", busy_g, 0);
         chk("post_rst_note", note_g, 0);
      end

      // No gap: back-to-back notes, 96 busy cycles.
      pulse_stop();
      pulse_start();
      check_pass(1'b1, -1, -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Autonomous tune player that sits directly upstream of the `music_notes` tone generator. It steps through a fixed 16-entry song table and drives the generator's 8-bit one-hot note select with each note for a programmed duration, separated by silent gaps. Its `note_sel` output connects straight to `music_notes.dip_switches`, replacing the manual DIP switches.

## Interface
- `TICK_DIV`, default 50000: clock cycles per tempo tick; must be ≥ 2.
- `GAP_TICKS`, default 1: silent ticks after every note; 0 means no gap.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: level-sampled each cycle; acted on only in IDLE.
- `stop`  in  1: aborts playback from any state.
- `loop_en`  in  1: sampled at end of song; 1 means restart at step 0.
- `note_sel`  out  8: one-hot note code to `music_notes`; 0 means silence.
- `busy`  out  1: high in PLAY or GAP.
- `done`  out  1: one-cycle pulse on natural song completion.
- `step_idx`  out  4: index of the current table entry.

## Operation
- **Song table.** Internal constant, 16 entries, each holding {note[2:0], dur[2:0]}.
  - Entry i (0–7): note = i, dur = 1 tick.
  - Entry i (8–15): note = 15−i, dur = 2 ticks.
  - `note_sel` = 1 << note while playing.
- **FSM states.** IDLE, PLAY, GAP.
- **Tick counter.** Width $clog2(TICK_DIV).
  - Counts 0..TICK_DIV−1 and wraps; `tick` is asserted at count TICK_DIV−1.
  - Cleared on every state entry; held at 0 in IDLE.
- **Remaining-ticks counter.** 3 bits.
  - Loaded with dur on PLAY entry, or with GAP_TICKS on GAP entry.
  - Decrements on each `tick`.
- **IDLE.** If `start`=1 and `stop`=0: go to PLAY, `step_idx`=0.
- **PLAY.**
  - `note_sel` = one-hot of the entry's note.
  - On a `tick` with remaining=1: go to GAP, or if GAP_TICKS=0 apply the end-of-step rule directly.
- **GAP.**
  - `note_sel`=0.
  - On a `tick` with remaining=1: apply the end-of-step rule.
- **End-of-step rule.**
  - If `step_idx`<15: `step_idx`+1, go to PLAY.
  - If `step_idx`=15 and `loop_en`=1: `step_idx`=0, go to PLAY. No `done`.
  - If `step_idx`=15 and `loop_en`=0: go to IDLE, pulse `done`.
- **stop.**
  - In any state: next cycle is IDLE, `note_sel`=0, `step_idx`=0, no `done`.
  - `stop` and `start` asserted together in IDLE: stop wins, the sequencer stays IDLE.
- **start while busy.** Ignored; does not restart the song.
- **Reset.** Asynchronous. Forces IDLE and sets `note_sel`=0, `busy`=0, `done`=0, `step_idx`=0, both counters 0.

## Timing
- All outputs are registered.
- `note_sel`, `busy` and `step_idx` update together, in the cycle after the controlling event (start, final tick, stop).
- Start latency: `start` sampled at edge N gives `busy`=1 and `note_sel`=8'h01 from edge N+1.
- Note duration: exactly dur × TICK_DIV cycles.
- Gap duration: exactly GAP_TICKS × TICK_DIV cycles.
- No idle cycles between a gap and the next note.
- Full song length, for TICK_DIV=4 and GAP_TICKS=1:
  - Steps 0–7: 8 × (4+4) = 64 cycles.
  - Steps 8–15: 8 × (8+4) = 96 cycles.
  - Total: 160 cycles of `busy`.
- `done` is high for exactly one cycle: the first cycle with `busy`=0. It never coincides with `busy`=1.
- Loop wrap: the step-15 gap is followed immediately by step 0 (`note_sel`=8'h01), with `busy` held high throughout.
- `rst` asserted mid-note: `note_sel` goes to 0 asynchronously, with no wait for a clock edge.

## Test plan
- **Reset.** Assert `rst` mid-PLAY → `note_sel`=0, `busy`=0, `step_idx`=0 immediately. After release, outputs hold until `start`.
- **Single pass.** TICK_DIV=4, GAP_TICKS=1, `loop_en`=0, 1-cycle `start` → `note_sel` sequence 01,0,02,0,…,80,0,80,0,40,…,01,0. Step 0 lasts 4 cycles and step 8 lasts 8. `busy` stays high 160 cycles, then `done`=1 for 1 cycle.
- **Loop.** Same setup with `loop_en`=1 → after cycle 160, `note_sel`=8'h01 again, `step_idx`=0, `busy` never drops, `done` never fires. Clearing `loop_en` during the second pass → `done` at cycle 320.
- **Stop.** Assert `stop` at step 5 mid-note → next cycle `note_sel`=0, `busy`=0, `step_idx`=0, `done`=0. A later `start` restarts at step 0.
- **Conflicts.** `start`+`stop` in the same IDLE cycle → stays IDLE. `start` pulsed at step 3 → playback unaffected; step timing matches the single-pass case.
- **No gap.** GAP_TICKS=0 → notes back-to-back with no zero cycles in `note_sel`. Total `busy` = 8×4 + 8×8 = 96 cycles.
